sig_field_parser: RTL and testbench

Downstream of the OFDM decoder's byte packer. Collects the three decoded L-SIG bytes (24 bits), checks them for errors, and turns a valid field into DATA-stage decode parameters: rate, length, data bits per symbol, symbol count and pad bits. Symbol count comes from a 16-iteration sequential divider. Errors raise a pulsed error flag with a cause vector so the receive controller can abort the packet.

---
 rtl/sig_field_parser_if.sv | 32 +++
 rtl/sig_field_parser.sv | 167 ++++++++++++++++
 tb/tb_sig_field_parser.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sig_field_parser_if.sv
// L-SIG parser port bundle: byte-in side, control, and decoded result side.
// Purely structural; no latency of its own.
// No backpressure: the producer strobes bytes and the parser drops the ones it cannot use.
interface sig_field_parser_if;
  logic        enable;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_in_strobe;
  logic        busy;
  logic        sig_valid;
  logic        sig_error;
  logic [3:0]  err_cause;
  logic [3:0]  rate_out;
  logic [11:0] length_out;
  logic [7:0]  n_dbps;
  logic [15:0] n_sym;
  logic [7:0]  pad_bits;

  // Receive controller / byte packer side.
  modport master (
    output enable, start, byte_in, byte_in_strobe,
    input  busy, sig_valid, sig_error, err_cause, rate_out, length_out,
           n_dbps, n_sym, pad_bits
  );

  // Parser side.
  modport slave (
    input  enable, start, byte_in, byte_in_strobe,
    output busy, sig_valid, sig_error, err_cause, rate_out, length_out,
           n_dbps, n_sym, pad_bits
  );
endinterface

// File: rtl/sig_field_parser.sv
// L-SIG parser: collects 3 bytes, validates the field, derives rate/length/n_dbps/n_sym/pad.
// Latency after the third byte strobe: sig_error 2 cycles, sig_valid 19 cycles (16-step divider).
// No backpressure: bytes outside COLLECT or while enable is low are dropped.
module sig_field_parser (
  input  logic              clock,
  input  logic              reset,
  sig_field_parser_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_CHECK, S_DIVIDE, S_FINISH, S_DONE, S_ERR
  } state_t;

  state_t      state, next_state;

  logic [23:0] field;       // {byte2, byte1, byte0}, bit i = b_i in air order
  logic [1:0]  byte_cnt;
  logic [3:0]  div_cnt;
  logic [15:0] div_q;       // dividend shifts out of the top, quotient shifts in at the bottom
  logic [15:0] div_r;       // partial remainder

  logic        busy_r, sig_valid_r, sig_error_r;
  logic [3:0]  err_cause_r, rate_r;
  logic [11:0] length_r;
  logic [7:0]  n_dbps_r, pad_r;
  logic [15:0] n_sym_r;

  // Field checks and rate decode, evaluated combinationally from the collected bytes.
  logic [3:0]  chk_rate;
  logic [11:0] chk_len;
  logic [7:0]  chk_dbps;
  logic [3:0]  chk_cause;
  always_comb begin
    chk_rate = {field[0], field[1], field[2], field[3]};
    chk_len  = field[16:5];
    case (chk_rate)
      4'b1101: chk_dbps = 8'd24;
      4'b1111: chk_dbps = 8'd36;
      4'b0101: chk_dbps = 8'd48;
      4'b0111: chk_dbps = 8'd72;
      4'b1001: chk_dbps = 8'd96;
      4'b1011: chk_dbps = 8'd144;
      4'b0001: chk_dbps = 8'd192;
      4'b0011: chk_dbps = 8'd216;
      default: chk_dbps = 8'd0;
    endcase
    chk_cause = {(chk_len == 12'd0), (field[23:18] != 6'd0),
                 (chk_dbps == 8'd0), (^field[17:0])};
  end

  // One restoring-division step plus the ceiling/pad correction used in FINISH.
  logic [15:0] rem_shift, rem_sub, fin_nsym;
  logic        rem_ge, rem_nz;
  logic [7:0]  fin_pad;
  always_comb begin
    rem_shift = {div_r[14:0], div_q[15]};
    rem_ge    = (rem_shift >= {8'd0, n_dbps_r});
    rem_sub   = rem_shift - {8'd0, n_dbps_r};
    rem_nz    = (div_r != 16'd0);
    fin_nsym  = div_q + {15'd0, rem_nz};
    fin_pad   = rem_nz ? (n_dbps_r - div_r[7:0]) : 8'd0;
  end

  // State register; enable freezes the machine.
  always_ff @(posedge clock) begin
    if (reset)           state <= S_IDLE;
    else if (bus.enable) state <= next_state;
  end

  // Next-state logic; start restarts from any state.
  always_comb begin
    next_state = state;
    if (bus.start) begin
      next_state = S_COLLECT;
    end else begin
      case (state)
        S_IDLE:    next_state = S_IDLE;
        S_COLLECT: if (bus.byte_in_strobe && byte_cnt == 2'd2) next_state = S_CHECK;
        S_CHECK:   next_state = (chk_cause != 4'd0) ? S_ERR : S_DIVIDE;
        S_DIVIDE:  if (div_cnt == 4'd15) next_state = S_FINISH;
        S_FINISH:  next_state = S_DONE;
        S_DONE:    next_state = S_IDLE;
        S_ERR:     next_state = S_IDLE;
        default:   next_state = S_IDLE;
      endcase
    end
  end

  // Byte collector and divider datapath.
  always_ff @(posedge clock) begin
    if (reset) begin
      field    <= 24'd0;
      byte_cnt <= 2'd0;
      div_cnt  <= 4'd0;
      div_q    <= 16'd0;
      div_r    <= 16'd0;
    end else if (bus.enable) begin
      if (bus.start) begin
        byte_cnt <= 2'd0;
      end else begin
        case (state)
          S_COLLECT: if (bus.byte_in_strobe) begin
            case (byte_cnt)
              2'd0:    field[7:0]   <= bus.byte_in;
              2'd1:    field[15:8]  <= bus.byte_in;
              default: field[23:16] <= bus.byte_in;
            endcase
            byte_cnt <= byte_cnt + 2'd1;
          end
          S_CHECK: begin
            div_q   <= {1'b0, chk_len, 3'b000} + 16'd22;
            div_r   <= 16'd0;
            div_cnt <= 4'd0;
          end
          S_DIVIDE: begin
            div_r   <= rem_ge ? rem_sub : rem_shift;
            div_q   <= {div_q[14:0], rem_ge};
            div_cnt <= div_cnt + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Registered outputs: pulses/busy follow the next state, results latch in CHECK and FINISH.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_r      <= 1'b0;
      sig_valid_r <= 1'b0;
      sig_error_r <= 1'b0;
      err_cause_r <= 4'd0;
      rate_r      <= 4'd0;
      length_r    <= 12'd0;
      n_dbps_r    <= 8'd0;
      n_sym_r     <= 16'd0;
      pad_r       <= 8'd0;
    end else if (bus.enable) begin
      busy_r      <= (next_state == S_COLLECT) || (next_state == S_CHECK) ||
                     (next_state == S_DIVIDE)  || (next_state == S_FINISH);
      sig_valid_r <= (next_state == S_DONE);
      sig_error_r <= (next_state == S_ERR);
      if (bus.start) begin
        err_cause_r <= 4'd0;
      end else if (state == S_CHECK) begin
        err_cause_r <= chk_cause;
        rate_r      <= chk_rate;
        length_r    <= chk_len;
        n_dbps_r    <= chk_dbps;
      end else if (state == S_FINISH) begin
        n_sym_r     <= fin_nsym;
        pad_r       <= fin_pad;
      end
    end
  end

  assign bus.busy       = busy_r;
  assign bus.sig_valid  = sig_valid_r;
  assign bus.sig_error  = sig_error_r;
  assign bus.err_cause  = err_cause_r;
  assign bus.rate_out   = rate_r;
  assign bus.length_out = length_r;
  assign bus.n_dbps     = n_dbps_r;
  assign bus.n_sym      = n_sym_r;
  assign bus.pad_bits   = pad_r;

endmodule

// File: tb/tb_sig_field_parser.sv
// Directed bench for sig_field_parser with a queue scoreboard of expected results.
// Expected latency/values come from constants and a behavioural model of the field.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_sig_field_parser;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  sig_field_parser_if bus();
  sig_field_parser dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic        is_err;
    logic [3:0]  cause;
    logic [3:0]  rate;
    logic [11:0] len;
    logic [7:0]  dbps;
    logic [15:0] nsym;
    logic [7:0]  pad;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;
  logic [3:0] rate_tab [8] = '{4'b1101, 4'b1111, 4'b0101, 4'b0111,
                               4'b1001, 4'b1011, 4'b0001, 4'b0011};

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic is_err, input logic [3:0] cause, input logic [3:0] rate,
                              input logic [11:0] len, input logic [7:0] dbps,
                              input logic [15:0] nsym, input logic [7:0] pad, input int lat);
    exp_t e;
    e.is_err = is_err; e.cause = cause; e.rate = rate; e.len = len;
    e.dbps = dbps; e.nsym = nsym; e.pad = pad; e.lat = lat;
    return e;
  endfunction

  // Reference decode of the three bytes using plain integer arithmetic.
  function automatic exp_t model(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    exp_t e;
    logic [23:0] f;
    int len, dbps, bits, nsym;
    f = {b2, b1, b0};
    e.rate = {f[0], f[1], f[2], f[3]};
    len = int'(f[16:5]);
    dbps = 0;
    for (int i = 0; i < 8; i++)
      if (rate_tab[i] == e.rate) dbps = (i == 0) ? 24 : (i == 1) ? 36 : (i == 2) ? 48 :
                                       (i == 3) ? 72 : (i == 4) ? 96 : (i == 5) ? 144 :
                                       (i == 6) ? 192 : 216;
    e.cause  = {(len == 0), (f[23:18] != 6'd0), (dbps == 0), (^f[17:0])};
    e.is_err = (e.cause != 4'd0);
    e.len    = f[16:5];
    e.dbps   = 8'(dbps);
    bits     = 8 * len + 22;
    nsym     = (dbps == 0) ? 0 : (bits + dbps - 1) / dbps;
    e.nsym   = 16'(nsym);
    e.pad    = 8'(nsym * dbps - bits);
    e.lat    = e.is_err ? 2 : 19;
    return e;
  endfunction

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
  endtask

  task automatic put_byte(input logic [7:0] b);
    bus.byte_in = b;
    bus.byte_in_strobe = 1'b1;
    tick();
    bus.byte_in_strobe = 1'b0;
  endtask

  task automatic put3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    put_byte(b0);
    put_byte(b1);
    put_byte(b2);
  endtask

  // Wait (bounded) for a result pulse, then pop the scoreboard and compare.
  task automatic wait_result(input int lat0);
    int lat;
    logic got;
    exp_t e;
    lat = lat0;
    while (!(bus.sig_valid || bus.sig_error) && lat < 80) begin
      tick();
      lat++;
    end
    got = bus.sig_valid || bus.sig_error;
    check("pulse_seen", got, 1);
    if (got && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("latency", lat, e.lat);
      check("sig_valid", bus.sig_valid, !e.is_err);
      check("sig_error", bus.sig_error, e.is_err);
      check("busy_at_pulse", bus.busy, 0);
      check("err_cause", bus.err_cause, e.cause);
      check("rate_out", bus.rate_out, e.rate);
      check("length_out", bus.length_out, e.len);
      if (!e.is_err) begin
        check("n_dbps", bus.n_dbps, e.dbps);
        check("n_sym", bus.n_sym, e.nsym);
        check("pad_bits", bus.pad_bits, e.pad);
      end
      tick();
      check("pulse_drop", {bus.sig_valid, bus.sig_error}, 0);
      if (!e.is_err) check("n_sym_hold", bus.n_sym, e.nsym);
      else           check("err_cause_hold", bus.err_cause, e.cause);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_valid"}, bus.sig_valid, 0);
    check({tag, "_error"}, bus.sig_error, 0);
    check({tag, "_cause"}, bus.err_cause, 0);
    check({tag, "_rate"}, bus.rate_out, 0);
    check({tag, "_len"}, bus.length_out, 0);
    check({tag, "_dbps"}, bus.n_dbps, 0);
    check({tag, "_nsym"}, bus.n_sym, 0);
    check({tag, "_pad"}, bus.pad_bits, 0);
  endtask

  initial begin
    logic [23:0] f;
    logic [3:0]  r;
    logic [11:0] l;
    int pulses;

    reset = 1'b1;
    bus.enable = 1'b1;
    bus.start = 1'b0;
    bus.byte_in = 8'd0;
    bus.byte_in_strobe = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // 6 Mb/s, length 100
    do_start();
    exp_q.push_back(mk(1'b0, 4'b0000, 4'b1101, 12'd100, 8'd24, 16'd35, 8'd18, 19));
    put3(8'h8B, 8'h0C, 8'h00);
    wait_result(1);

    // 54 Mb/s, length 4095 (largest dividend)
    do_start();
    exp_q.push_back(mk(1'b0, 4'b0000, 4'b0011, 12'd4095, 8'd216, 16'd152, 8'd50, 19));
    put3(8'hEC, 8'hFF, 8'h01);
    wait_result(1);

    // parity error
    do_start();
    exp_q.push_back(mk(1'b1, 4'b0001, 4'b1101, 12'd100, 8'd0, 16'd0, 8'd0, 2));
    put3(8'h8B, 8'h0C, 8'h02);
    wait_result(1);

    // invalid rate
    do_start();
    exp_q.push_back(mk(1'b1, 4'b0010, 4'b0000, 12'd100, 8'd0, 16'd0, 8'd0, 2));
    put3(8'h80, 8'h0C, 8'h02);
    wait_result(1);

    // zero length together with nonzero tail, parity kept even
    do_start();
    exp_q.push_back(mk(1'b1, 4'b1100, 4'b1101, 12'd0, 8'd0, 16'd0, 8'd0, 2));
    put3(8'h0B, 8'h00, 8'h06);
    wait_result(1);

    // b16 set gives length 2048, so only the tail check trips here
    do_start();
    exp_q.push_back(model(8'h0B, 8'h00, 8'h05));
    put3(8'h0B, 8'h00, 8'h05);
    wait_result(1);

    // random valid fields through the reference model
    for (int k = 0; k < 5; k++) begin
      r = rate_tab[$urandom_range(7, 0)];
      l = (k == 0) ? 12'd1 : 12'($urandom_range(4095, 1));
      f = 24'd0;
      f[3:0]  = {r[0], r[1], r[2], r[3]};
      f[16:5] = l;
      f[17]   = ^f[16:0];
      do_start();
      exp_q.push_back(model(f[7:0], f[15:8], f[23:16]));
      put3(f[7:0], f[15:8], f[23:16]);
      wait_result(1);
    end

    // reset in the middle of DIVIDE clears everything and suppresses the pulse
    do_start();
    put3(8'h8B, 8'h0C, 8'h00);
    repeat (8) tick();
    reset = 1'b1;
    tick();
    check_all_zero("mid_div_reset");
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (bus.sig_valid || bus.sig_error) pulses++;
    end
    check("no_pulse_after_reset", pulses, 0);

    // restart after two bytes, then a start that coincides with a strobe
    do_start();
    put_byte(8'hFF);
    put_byte(8'hFF);
    bus.start = 1'b1;
    bus.byte_in = 8'hAA;
    bus.byte_in_strobe = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.byte_in_strobe = 1'b0;
    check("err_cause_cleared", bus.err_cause, 0);
    exp_q.push_back(mk(1'b0, 4'b0000, 4'b1101, 12'd100, 8'd24, 16'd35, 8'd18, 19));
    put3(8'h8B, 8'h0C, 8'h00);
    wait_result(1);

    // strobe lost while enable low, then a 4-cycle freeze during DIVIDE
    do_start();
    bus.enable = 1'b0;
    put_byte(8'h55);
    bus.enable = 1'b1;
    exp_q.push_back(mk(1'b0, 4'b0000, 4'b0011, 12'd4095, 8'd216, 16'd152, 8'd50, 23));
    put3(8'hEC, 8'hFF, 8'h01);
    repeat (5) tick();
    bus.enable = 1'b0;
    repeat (4) tick();
    bus.enable = 1'b1;
    wait_result(10);

    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
